// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates the register file's single write port between
// ALU (A) and load (B) sources, tracks pending writes and flags decode hazards.
module regfile_wb_ctrl #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        Clk,
  input  logic        rst_n,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard,
  output logic [31:0] busy,
  output logic        WEN,
  output logic [4:0]  Write_reg,
  output logic [31:0] Write_data
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0]  starve;
  logic [2:0]  starve_nxt;
  logic        a_gnt;
  logic        b_gnt;
  logic        hs;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic [31:0] busy_q;
  logic [31:0] busy_nxt;
  logic        rs1_busy;
  logic        rs2_busy;

  // B (loads) has priority; A wins only once it has lost STARVE_MAX contended cycles.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (a_valid && b_valid) begin
      if (starve == STARVE_LIM) a_gnt = 1'b1;
      else                      b_gnt = 1'b1;
    end else if (a_valid) begin
      a_gnt = 1'b1;
    end else if (b_valid) begin
      b_gnt = 1'b1;
    end
  end

  assign a_ready = a_gnt;
  assign b_ready = b_gnt;
  assign hs      = a_gnt || b_gnt;

  always_comb begin
    sel_rd   = b_rd;
    sel_data = b_data;
    if (a_gnt) begin
      sel_rd   = a_rd;
      sel_data = a_data;
    end
  end

  always_comb begin
    starve_nxt = starve;
    if (!a_valid || a_gnt)   starve_nxt = '0;
    else if (b_gnt)          starve_nxt = starve + 3'd1;
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) starve <= '0;
    else        starve <= starve_nxt;
  end

  // x0 handshakes are accepted but never raise WEN, so they cannot touch the file.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      WEN        <= 1'b0;
      Write_reg  <= '0;
      Write_data <= '0;
    end else begin
      WEN <= hs && (sel_rd != '0);
      if (hs) begin
        Write_reg  <= sel_rd;
        Write_data <= sel_data;
      end
    end
  end

  // Set is applied after clear so a new producer issued on the commit edge keeps the bit.
  always_comb begin
    busy_nxt = busy_q;
    if (WEN) busy_nxt[Write_reg] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  assign busy     = busy_q;
  assign rs1_busy = (rs1 != '0) && busy_q[rs1];
  assign rs2_busy = (rs2 != '0) && busy_q[rs2];
  assign hazard   = rs1_busy || rs2_busy;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized and directed bench for regfile_wb_ctrl against a cycle-level reference model.
module tb_regfile_wb_ctrl;

  localparam int SMAX = 3;

  logic        Clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic [31:0] busy;
  logic        WEN;
  logic [4:0]  Write_reg;
  logic [31:0] Write_data;

  regfile_wb_ctrl #(.STARVE_MAX(SMAX)) dut (
    .Clk(Clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rs1(rs1), .rs2(rs2), .hazard(hazard), .busy(busy),
    .WEN(WEN), .Write_reg(Write_reg), .Write_data(Write_data)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: pending-register set, lost-contention count, committed write slot.
  bit          m_pend [32];
  int          m_lost;
  bit          m_wen;
  bit [4:0]    m_wreg;
  bit [31:0]   m_wdata;
  bit          e_ga;
  bit          e_gb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [31:0] pend_vec();
    bit [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_lost = 0;
    m_wen = 1'b0;
    m_wreg = '0;
    m_wdata = '0;
  endtask

  task automatic model_check();
    bit hz;
    if (a_valid && b_valid) begin
      e_ga = (m_lost == SMAX);
      e_gb = !e_ga;
    end else begin
      e_ga = a_valid;
      e_gb = b_valid;
    end
    hz = (rs1 != 0 && m_pend[rs1]) || (rs2 != 0 && m_pend[rs2]);
    check("a_ready", a_ready, e_ga);
    check("b_ready", b_ready, e_gb);
    check("ready_excl", a_ready & b_ready, 0);
    check("hazard", hazard, hz);
    check("busy", busy, pend_vec());
    check("WEN", WEN, m_wen);
    check("Write_reg", Write_reg, m_wreg);
    check("Write_data", Write_data, m_wdata);
  endtask

  task automatic drive(input logic iv, input logic [4:0] ird,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge Clk);
    iss_valid = iv; iss_rd = ird;
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    rs1 = r1; rs2 = r2;
    #1;
    model_check();
  endtask

  task automatic advance();
    bit        hs;
    bit [4:0]  rd;
    bit [31:0] d;
    @(posedge Clk);
    if (rst_n) begin
      hs = e_ga || e_gb;
      rd = e_ga ? a_rd : b_rd;
      d  = e_ga ? a_data : b_data;
      if (m_wen) m_pend[m_wreg] = 1'b0;
      if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      m_lost = (a_valid && b_valid && e_gb) ? m_lost + 1 : 0;
      m_wen = hs && (rd != 0);
      if (hs) begin
        m_wreg = rd;
        m_wdata = d;
      end
    end
  endtask

  task automatic idle(input logic [4:0] r1);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, 5'd0);
  endtask

  bit [31:0] busy_snap;

  initial begin
    rst_n = 1'b0;
    iss_valid = 1'b0; iss_rd = '0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    rs1 = '0; rs2 = '0;
    model_reset();
    #1;
    check("rst_WEN", WEN, 0);
    check("rst_busy", busy, 0);
    check("rst_hazard", hazard, 0);
    #20 rst_n = 1'b1;

    // Single write: issue x5 at edge 0, A handshake at edge 3.
    drive(1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    advance();
    for (int c = 1; c <= 2; c++) begin
      idle(5'd5);
      check("sw_hazard_mid", hazard, 1);
      advance();
    end
    drive(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    check("sw_hazard_c3", hazard, 1);
    check("sw_a_ready", a_ready, 1);
    advance();
    idle(5'd5);
    check("sw_hazard_c4", hazard, 1);
    check("sw_WEN_c4", WEN, 1);
    check("sw_reg_c4", Write_reg, 5);
    check("sw_data_c4", Write_data, 32'hDEADBEEF);
    advance();
    idle(5'd5);
    check("sw_busy5_c5", busy[5], 0);
    check("sw_hazard_c5", hazard, 0);
    advance();

    // Contention: B,B,B,A repeating after a cycle with A idle.
    idle(5'd0);
    advance();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 5'd0, 1'b1, 5'(1 + i), $urandom, 1'b1, 5'(20 + i % 8), $urandom, 5'd0, 5'd0);
      check("cont_a_ready", a_ready, (i % 4) == 3);
      check("cont_b_ready", b_ready, (i % 4) != 3);
      advance();
    end

    // x0 write: accepted, WEN stays low, scoreboard untouched.
    idle(5'd0);
    advance();
    drive(1'b0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("x0_a_ready", a_ready, 1);
    busy_snap = busy;
    advance();
    idle(5'd0);
    check("x0_WEN", WEN, 0);
    check("x0_busy", busy, busy_snap);
    advance();

    // Set/clear collision on x7.
    drive(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    advance();
    drive(1'b0, 5'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    advance();
    drive(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    check("col_WEN", WEN, 1);
    check("col_reg", Write_reg, 7);
    advance();
    idle(5'd7);
    check("col_busy7", busy[7], 1);
    check("col_hazard", hazard, 1);
    advance();

    // Issue to x0 never marks x0 and never raises hazard.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("x0hz_hazard", hazard, 0);
    advance();
    idle(5'd0);
    check("x0hz_busy0", busy[0], 0);
    check("x0hz_hazard2", hazard, 0);
    advance();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 1), 5'($urandom),
            $urandom_range(0, 9) < 6, 5'($urandom), $urandom,
            $urandom_range(0, 9) < 6, 5'($urandom), $urandom,
            5'($urandom), 5'($urandom));
      advance();
    end

    // Asynchronous reset mid-stream with both sources valid and a busy bit set.
    drive(1'b1, 5'd9, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 5'd9, 5'd0);
    advance();
    drive(1'b0, 5'd0, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 5'd9, 5'd0);
    check("pre_rst_busy9", busy[9], 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mrst_WEN", WEN, 0);
    check("mrst_reg", Write_reg, 0);
    check("mrst_data", Write_data, 0);
    check("mrst_busy", busy, 0);
    check("mrst_hazard", hazard, 0);
    check("mrst_b_ready", b_ready, 1);
    check("mrst_a_ready", a_ready, 0);
    advance();
    #2 rst_n = 1'b1;
    drive(1'b0, 5'd0, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 5'd0, 5'd0);
    check("post_rst_first_b", b_ready, 1);
    advance();
    idle(5'd0);
    check("post_rst_WEN", WEN, 1);
    check("post_rst_reg", Write_reg, 4);
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
